// File: rtl/ifetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, 2-entry instruction queue,
// and redirect handling that discards stale in-flight responses.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] prog,
  output logic [31:0] prog_pc,
  output logic        prog_valid,
  input  logic        prog_ready
);

  logic [31:0] r_fetch_pc;
  logic [31:0] r_rsp_pc;
  logic [1:0]  r_live;
  logic [1:0]  r_drop;
  logic [1:0]  r_occ;
  logic [31:0] r_q0_insn;
  logic [31:0] r_q0_pc;
  logic [31:0] r_q1_insn;
  logic [31:0] r_q1_pc;

  logic [2:0]  w_used;
  logic        w_pop;
  logic        w_fire;
  logic        w_rsp_drop;
  logic        w_rsp_live;
  logic        w_push;
  logic [31:0] w_target;
  logic [1:0]  w_live_nxt;
  logic [1:0]  w_drop_nxt;
  logic [1:0]  w_occ_nxt;

  // Every slot is either in flight (live or stale) or occupied, so a live response always fits.
  assign w_used         = {1'b0, r_live} + {1'b0, r_drop} + {1'b0, r_occ};
  assign w_pop          = prog_valid & prog_ready;
  assign imem_req_valid = !rst && (w_used < (3'd2 + {2'b00, w_pop}));
  assign w_fire         = imem_req_valid & imem_req_ready;
  assign imem_addr      = r_fetch_pc;

  assign w_rsp_drop = imem_rsp_valid && (r_drop != 2'd0);
  assign w_rsp_live = imem_rsp_valid && (r_drop == 2'd0);
  assign w_push     = w_rsp_live && !redirect;
  assign w_target   = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_live_nxt = r_live;
    w_drop_nxt = r_drop;
    w_occ_nxt  = r_occ;
    if (redirect) begin
      // Everything still in flight becomes stale; a response this cycle retires one of them.
      w_live_nxt = '0;
      w_drop_nxt = r_drop + r_live + {1'b0, w_fire} - {1'b0, imem_rsp_valid};
      w_occ_nxt  = '0;
    end else begin
      w_live_nxt = r_live + {1'b0, w_fire} - {1'b0, w_rsp_live};
      w_drop_nxt = r_drop - {1'b0, w_rsp_drop};
      w_occ_nxt  = r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_live     <= '0;
      r_drop     <= '0;
      r_occ      <= '0;
    end else begin
      r_live <= w_live_nxt;
      r_drop <= w_drop_nxt;
      r_occ  <= w_occ_nxt;
      if (redirect) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) r_rsp_pc   <= r_rsp_pc + 32'd4;
      end
    end
  end

  // Queue payload needs no reset: visibility is governed solely by r_occ.
  always_ff @(posedge clk) begin
    if (w_push && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
      r_q0_insn <= imem_rdata;
      r_q0_pc   <= r_rsp_pc;
    end else if (w_pop) begin
      r_q0_insn <= r_q1_insn;
      r_q0_pc   <= r_q1_pc;
    end
    if (w_push && (((r_occ == 2'd1) && !w_pop) || (r_occ == 2'd2))) begin
      r_q1_insn <= imem_rdata;
      r_q1_pc   <= r_rsp_pc;
    end
  end

  assign prog_valid = (r_occ != 2'd0);
  assign prog       = prog_valid ? r_q0_insn : NOP_INSN;
  assign prog_pc    = prog_valid ? r_q0_pc : 32'h0000_0000;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: in-order memory model with programmable latency and a
// scoreboard of expected delivered PCs and request addresses.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] MAGIC  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] prog;
  logic [31:0] prog_pc;
  logic        prog_valid;
  logic        prog_ready;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .prog           (prog),
    .prog_pc        (prog_pc),
    .prog_valid     (prog_valid),
    .prog_ready     (prog_ready)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          npop = 0;
  int          hold_err = 0;
  int          credit_bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        prev_stall = 1'b0;
  logic        prev_ctl = 1'b1;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive the memory response for this cycle, let logic settle, then score the cycle.
  task automatic sample();
    logic fire;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = pend_addr[0] ^ MAGIC;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
    end
    #1;
    if (prev_stall && !prev_ctl && imem_req_valid && imem_addr != prev_addr) hold_err++;
    fire = imem_req_valid & imem_req_ready;
    if (prog_valid && prog_ready) begin
      chk("pop_pc", prog_pc, exp_pc);
      chk("pop_insn", prog, exp_pc ^ MAGIC);
      exp_pc = exp_pc + 32'd4;
      npop++;
    end
    if (fire) begin
      chk("req_addr", imem_addr, exp_req);
      exp_req = exp_req + 32'd4;
    end
    if (rst) begin
      exp_pc  = RST_PC;
      exp_req = RST_PC;
    end else if (redirect) begin
      exp_pc  = redirect_pc & 32'hFFFF_FFFC;
      exp_req = redirect_pc & 32'hFFFF_FFFC;
    end
    if (imem_rsp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (fire) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
    end
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end
    if (pend_addr.size() > 2) credit_bad++;
    prev_stall = imem_req_valid & !imem_req_ready;
    prev_ctl   = rst | redirect;
    prev_addr  = imem_addr;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  // Advance until prog_valid is seen in a sampled cycle, then compare its PC.
  task automatic wait_valid(input string tag, input logic [31:0] pc, input int limit);
    logic found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      sample();
      if (prog_valid) begin
        found = 1'b1;
        chk(tag, prog_pc, pc);
      end
      adv();
    end
    if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n0;
    logic found;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    prog_ready = 1'b0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rdata = '0;
    exp_pc = RST_PC; exp_req = RST_PC;
    @(posedge clk); #1;

    // Reset state
    run(2);
    sample();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_prog_valid", {31'd0, prog_valid}, 32'd0);
    chk("rst_prog", prog, NOP);
    chk("rst_prog_pc", prog_pc, 32'd0);
    adv();

    // First request, latency, free-run throughput
    rst = 1'b0; prog_ready = 1'b1;
    sample();
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_addr, RST_PC);
    adv();
    sample();
    chk("lat_not_yet", {31'd0, prog_valid}, 32'd0);
    adv();
    sample();
    chk("lat_valid", {31'd0, prog_valid}, 32'd1);
    chk("lat_pc", prog_pc, RST_PC);
    adv();
    n0 = npop;
    run(20);
    chk("throughput", npop - n0, 32'd20);

    // Backpressure: queue fills and requests stop
    prog_ready = 1'b0;
    n0 = npop;
    run(9);
    sample();
    chk("bp_valid", {31'd0, prog_valid}, 32'd1);
    chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    adv();
    chk("bp_no_pop", npop - n0, 32'd0);
    prog_ready = 1'b1;
    run(10);

    // Redirect with two stale requests in flight (3-cycle memory)
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      sample();
      adv();
      if (pend_addr.size() == 2) found = 1'b1;
    end
    chk("stale_setup", {31'd0, found}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_2002;
    sample();
    adv();
    redirect = 1'b0;
    wait_valid("stale_first_pc", 32'h0000_2000, 20);

    // Redirect coincident with response, request fire and pop (1-cycle memory)
    lat = 1;
    run(8);
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    sample();
    chk("co_rsp", {31'd0, imem_rsp_valid}, 32'd1);
    chk("co_fire", {31'd0, imem_req_valid & imem_req_ready}, 32'd1);
    chk("co_pop", {31'd0, prog_valid}, 32'd1);
    adv();
    redirect = 1'b0;
    sample();
    chk("co_empty", {31'd0, prog_valid}, 32'd0);
    chk("co_new_req", {31'd0, imem_req_valid}, 32'd1);
    chk("co_new_addr", imem_addr, 32'h0000_3000);
    adv();
    sample();
    chk("co_r2_empty", {31'd0, prog_valid}, 32'd0);
    adv();
    sample();
    chk("co_r3_valid", {31'd0, prog_valid}, 32'd1);
    chk("co_r3_pc", prog_pc, 32'h0000_3000);
    adv();

    // Random request-ready stalls and consumer stalls
    lat = 2;
    n0 = npop;
    for (int i = 0; i < 80; i++) begin
      imem_req_ready = ($urandom_range(0, 2) != 0);
      prog_ready     = ($urandom_range(0, 3) != 0);
      sample();
      adv();
    end
    imem_req_ready = 1'b1; prog_ready = 1'b1;
    run(8);
    chk("stall_hold", hold_err, 32'd0);
    chk("stall_progress", {31'd0, npop > n0 + 20}, 32'd1);
    chk("credit", credit_bad, 32'd0);

    // Reset with a full queue, then refetch from RESET_PC
    lat = 1;
    prog_ready = 1'b0;
    run(6);
    sample();
    chk("mid_full", {31'd0, prog_valid}, 32'd1);
    adv();
    rst = 1'b1;
    sample();
    adv();
    rst = 1'b0; prog_ready = 1'b1;
    sample();
    chk("mid_cleared", {31'd0, prog_valid}, 32'd0);
    chk("mid_req", {31'd0, imem_req_valid}, 32'd1);
    chk("mid_addr", imem_addr, RST_PC);
    adv();
    wait_valid("mid_refetch_pc", RST_PC, 10);
    run(5);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    sample();
    adv();
    redirect = 1'b0;
    wait_valid("wrap_first", 32'hFFFF_FFFC, 10);
    sample();
    chk("wrap_second_valid", {31'd0, prog_valid}, 32'd1);
    chk("wrap_second_pc", prog_pc, 32'h0000_0000);
    adv();
    run(4);
    chk("credit_final", credit_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage feeding the instruction decoder. Holds the program counter and issues word fetches to instruction memory over a valid/ready request channel with in-order responses. Buffers returned instructions in a 2-entry queue and presents `prog` with its `prog_pc` to the decode stage under a valid/ready handshake. Accepts a redirect (jump or taken branch) that flushes the queue and discards stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `NOP_INSN`, default 32'h0000_0013 (`addi x0,x0,0`): value driven on `prog` when `prog_valid`=0.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_addr` out 32: fetch address, always word-aligned.
- `imem_rsp_valid` in 1: response data valid. Responses arrive in request order, at least 1 cycle after acceptance. There is no response backpressure.
- `imem_rdata` in 32: fetched instruction word.
- `redirect` in 1: one-cycle pulse; load a new PC.
- `redirect_pc` in 32: target PC; bits [1:0] are ignored and treated as 0.
- `prog` out 32: head instruction, to decoder `prog`.
- `prog_pc` out 32: address of `prog`.
- `prog_valid` out 1: head entry valid.
- `prog_ready` in 1: downstream consumes head this cycle.

## Operation
- **State:**
  - `fetch_pc` (next request address).
  - `rsp_pc` (address of the next live response).
  - `live` (live requests in flight, 0..2).
  - `drop` (stale requests in flight, 0..2).
  - Queue of 2 entries {insn, pc} with `occ` 0..2.
- **Derived signals:**
  - pop = `prog_valid & prog_ready`.
  - req_fire = `imem_req_valid & imem_req_ready`.
- **Credit rule:** `imem_req_valid` = !`rst` & (`live` + `drop` + `occ` − pop < 2).
  - This guarantees every live response has a queue slot.
  - There is a combinational path from `prog_ready` to `imem_req_valid`.
- **Address rules:**
  - `imem_addr` = `fetch_pc`.
  - No stability requirement while the request is unaccepted; the address may change on redirect.
- **Request fire:** on req_fire, `fetch_pc` += 4 (32-bit wrap, 0xFFFF_FFFC → 0x0000_0000).
- **Response handling** (`imem_rsp_valid`):
  - If `drop` > 0: `drop` −= 1 and the data is discarded.
  - Else: push {`imem_rdata`, `rsp_pc`}, `rsp_pc` += 4, `live` −= 1.
- **Queue:**
  - FIFO order; push and pop may occur in the same cycle.
  - Pushing into a full queue is impossible by the credit rule; the bench asserts this.
- **Redirect** (highest priority, same cycle as any other event):
  - `fetch_pc` ← `rsp_pc` ← {`redirect_pc`[31:2], 2'b00}.
  - The queue is flushed (`occ` ← 0); a pop in the same cycle is still honoured downstream, but no push occurs.
  - `drop` ← `drop` + `live` + req_fire − (`imem_rsp_valid` ? 1 : 0); `live` ← 0.
  - A response arriving in the redirect cycle is always discarded.
  - A request accepted in the redirect cycle was to the old PC and is counted stale.
- **Outputs:**
  - `prog`/`prog_pc` = head entry when `occ` > 0.
  - Otherwise `prog` = `NOP_INSN` and `prog_pc` = 0.
  - `prog_valid` = (`occ` > 0).
- **Reset:** all counters and `occ` are cleared, and `fetch_pc` = `rsp_pc` = `RESET_PC`. Any memory response arriving after reset is released must not be produced; the environment guarantees the memory is reset with the core.

## Timing
- **Reset values:**
  - `imem_req_valid` 0 (while `rst`=1).
  - `imem_addr` `RESET_PC`.
  - `prog_valid` 0, `prog` `NOP_INSN`, `prog_pc` 0.
- **First request:** asserted in the first cycle with `rst`=0.
- **Latency:** a response in cycle N gives `prog_valid`=1 with that data in cycle N+1 (registered queue, no bypass).
- **Throughput:** with 1-cycle memory and `prog_ready` held at 1, one instruction per cycle in steady state.
- **After redirect in cycle R:**
  - The request to the new PC can be issued in R+1 if credit allows.
  - The earliest valid new instruction appears at R+3 (1-cycle memory, no stale traffic).
- **Redirect and `rst` in the same cycle:** `rst` wins.

## Test plan
- **Reset then free-run:**
  - Setup: `RESET_PC`=0x100, 1-cycle memory returning addr^0xA5A5_0000, `prog_ready`=1.
  - Expected: `prog_pc` sequence 0x100, 0x104, 0x108, … on consecutive cycles, with `prog` matching.
- **Backpressure:**
  - Setup: `prog_ready`=0 for 10 cycles.
  - Expected: `occ` saturates at 2 and `imem_req_valid` drops. After release, no instruction is lost or duplicated and the order is preserved.
- **Redirect with stale responses:**
  - Setup: 3-cycle memory, 2 requests in flight, redirect to 0x2002.
  - Expected: both old responses are discarded and the next `prog_pc`=0x2000.
- **Redirect coincident with a response, a request fire and a pop:**
  - Expected: the response is dropped, the fired request is counted stale, the popped entry is delivered, and the queue is empty the next cycle.
- **`imem_req_ready` stalls:**
  - Setup: `imem_req_ready` low for random stretches.
  - Expected: `imem_addr` holds, no PC skipped, and `live` + `drop` + `occ` ≤ 2 at all times.
- **Reset mid-stream and PC wrap:**
  - Reset mid-stream: assert `rst` with a full queue. Expected: `prog_valid`=0 next cycle and refetch from `RESET_PC`.
  - PC wrap: redirect to 0xFFFF_FFFC. Expected: the next `prog_pc` values are 0xFFFF_FFFC then 0x0000_0000.
